// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg -- shared definitions for the RV32I pipeline stages.
// Holds the load/store opcodes, memory funct3 encodings, the canonical NOP
// and the MEM-stage FSM state type, plus decode helpers for memory ops.
package rv_pipe_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  // Unsupported funct3 values under the load/store opcodes decode as neither,
  // so such instructions flow through the stage like ALU ops.
  function automatic logic is_load_inst(input logic [31:0] inst);
    return (inst[6:0] == OPC_LOAD) &&
           (inst[14:12] inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic is_store_inst(input logic [31:0] inst);
    return (inst[6:0] == OPC_STORE) && (inst[14:12] inside {F3_B, F3_H, F3_W});
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align -- combinational byte-lane formatting for the data port.
// Stores: replicates the store byte/halfword across the word and produces
// the matching write strobes. Loads: picks the addressed byte/halfword out
// of the read word and sign- or zero-extends it.
//   funct3     in  3   memory access size/sign
//   byte_off   in  2   low address bits (lane select)
//   store_data in  32  raw rs2 store data
//   rdata      in  32  raw read word from memory
//   wdata      out 32  lane-replicated store data
//   wstrb      out 4   byte write strobes
//   load_data  out 32  extracted and extended load value
module lsu_lane_align
  import rv_pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a value held (a latch).
  always_comb begin
    lane_byte = rdata[7:0];
    case (byte_off)
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      2'd3:    lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    // Halfword lane ignores byte_off[0]; misaligned halves are masked.
    lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << byte_off;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {byte_off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage -- MEM stage of the 5-stage RV32I pipeline.
// Passes ALU results through in one cycle; loads and stores issue a
// registered req/ack data-memory access and stall upstream until the ack
// (or the optional ack timeout) retires the instruction.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (no memory request, misalign_fault pulse, NOP to writeback).
//   clk, rst        clock, synchronous active-high reset
//   mem_inst        instruction in MEM (NOP when empty)
//   mem_addr        effective address from EX
//   exe_result      ALU result, or store data for stores
//   dmem_*          registered data-memory request port; dmem_ack/rdata in
//   mem_stall       combinational hold for upstream stages
//   mem_result      registered WB / forwarding result
//   wb_inst         registered instruction for WB
//   bus_error       one-cycle pulse when an access times out
//   misalign_fault  one-cycle pulse on a trapped misaligned access
module mem_access_stage
  import rv_pipe_pkg::*;
#(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] exe_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_result,
  output logic [31:0] wb_inst,
  output logic        bus_error,
  output logic        misalign_fault
);

  localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT > 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(ACK_TIMEOUT - 1) : 32'd0;

  mem_state_t  state, next_state;
  logic        is_load, is_store, is_mem, trap;
  logic        issue, complete, abort, timeout_hit;
  logic [31:0] wait_cnt;
  logic [31:0] lane_wdata, lane_load;
  logic [3:0]  lane_wstrb;

  assign is_load  = is_load_inst(mem_inst);
  assign is_store = is_store_inst(mem_inst);
  assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((mem_inst[14:12] inside {F3_H, F3_HU}) && mem_addr[0]) ||
                      ((mem_inst[14:12] == F3_W) && (mem_addr[1:0] != 2'b00));
  assign trap = (state == IDLE) && is_mem && misaligned;

  always_ff @(posedge clk) begin
    if (rst) misalign_fault <= 1'b0;
    else     misalign_fault <= trap;
  end
`else
  assign trap           = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .funct3     (mem_inst[14:12]),
    .byte_off   (mem_addr[1:0]),
    .store_data (exe_result),
    .rdata      (dmem_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (lane_load)
  );

  // An ack arriving on the last allowed cycle still completes normally.
  assign timeout_hit = TIMEOUT_EN && (state == ACCESS) && !dmem_ack &&
                       (wait_cnt == TIMEOUT_LAST);

  always_comb begin
    next_state = state;
    mem_stall  = 1'b0;
    issue      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !trap) begin
          mem_stall  = 1'b1;
          issue      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          mem_stall  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
      mem_result <= 32'd0;
      wb_inst    <= NOP_INST;
      bus_error  <= 1'b0;
      wait_cnt   <= 32'd0;
    end else begin
      bus_error <= 1'b0;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {mem_addr[31:2], 2'b00};
        dmem_wdata <= is_store ? lane_wdata : 32'd0;
        dmem_wstrb <= is_store ? lane_wstrb : 4'd0;
        wait_cnt   <= 32'd0;
      end else if (state == ACCESS) begin
        // Upstream is frozen during ACCESS, so mem_inst/mem_addr still
        // describe the outstanding access when the ack arrives.
        if (complete) begin
          dmem_req   <= 1'b0;
          wb_inst    <= mem_inst;
          mem_result <= is_store ? exe_result : lane_load;
        end else if (abort) begin
          dmem_req   <= 1'b0;
          bus_error  <= 1'b1;
          wb_inst    <= NOP_INST;
          mem_result <= 32'd0;
        end else begin
          wait_cnt   <= wait_cnt + 32'd1;
        end
      end else if (trap) begin
        wb_inst    <= NOP_INST;
        mem_result <= 32'd0;
      end else begin
        wb_inst    <= mem_inst;
        mem_result <= exe_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage -- scoreboard bench for mem_access_stage.
// The driver issues directed instructions and pushes the expected writeback
// into a queue; a monitor pops and compares each time an instruction retires
// (mem_stall low with a non-NOP instruction in MEM at the clock edge).
module tb_mem_access_stage;
  import rv_pipe_pkg::*;

  localparam int TIMEOUT = 4;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SB   = 32'h00208023;
  localparam logic [31:0] I_SH   = 32'h00209023;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_LB   = 32'h00008283;
  localparam logic [31:0] I_LH   = 32'h00009283;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_LBU  = 32'h0000C283;
  localparam logic [31:0] I_LHU  = 32'h0000D283;
  localparam logic [31:0] I_LBAD = 32'h0000B283;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_inst, mem_addr, exe_result;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, bus_error, misalign_fault;
  logic [31:0] mem_result, wb_inst;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_inst       (mem_inst),
    .mem_addr       (mem_addr),
    .exe_result     (exe_result),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .mem_stall      (mem_stall),
    .mem_result     (mem_result),
    .wb_inst        (wb_inst),
    .bus_error      (bus_error),
    .misalign_fault (misalign_fault)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [31:0] inst;
    logic        berr;
    logic        mfault;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a retirement sampled at one falling edge is checked at the next.
  logic pend = 1'b0;
  exp_t got;
  always @(negedge clk) begin
    if (pend) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: retire with empty queue, wb_inst %h", wb_inst);
      end else begin
        got = sb_q.pop_front();
        check({got.name, "/mem_result"}, mem_result, got.result);
        check({got.name, "/wb_inst"}, wb_inst, got.inst);
        check({got.name, "/bus_error"}, {31'd0, bus_error}, {31'd0, got.berr});
        check({got.name, "/misalign_fault"}, {31'd0, misalign_fault}, {31'd0, got.mfault});
      end
    end
    pend = !rst && !mem_stall && (mem_inst !== NOP_INST);
  end

  // Drives one instruction from a drive point (2 time units after a rising
  // edge) until it retires; ack_delay = ACCESS cycles before ack (-1: never).
  task automatic run_op(input string name, input logic [31:0] inst, addr, data, rdata,
                        input int ack_delay, input bit exp_access,
                        input logic [31:0] exp_daddr, exp_wdata, input logic [3:0] exp_wstrb,
                        input int exp_stalls, input logic [31:0] exp_result, exp_wb,
                        input bit exp_berr, exp_mfault);
    int   stalls = 0;
    int   n_acc  = 0;
    bit   fin    = 1'b0;
    bit   saw_req = 1'b0;
    exp_t e;
    e.name = name; e.result = exp_result; e.inst = exp_wb;
    e.berr = exp_berr; e.mfault = exp_mfault;
    sb_q.push_back(e);
    mem_inst = inst; mem_addr = addr; exe_result = data; dmem_rdata = rdata;
    for (int c = 0; c < 64 && !fin; c++) begin
      if (dmem_req) begin
        if (!saw_req) begin
          check({name, "/dmem_addr"}, dmem_addr, exp_daddr);
          check({name, "/dmem_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_wstrb});
          check({name, "/dmem_we"}, {31'd0, dmem_we}, {31'd0, exp_wstrb != 4'd0});
          if (exp_wstrb != 4'd0) check({name, "/dmem_wdata"}, dmem_wdata, exp_wdata);
        end
        saw_req  = 1'b1;
        dmem_ack = (n_acc == ack_delay);
        n_acc++;
      end
      @(negedge clk);
      if (mem_stall) stalls++;
      else fin = 1'b1;
      @(posedge clk); #2;
      dmem_ack = 1'b0;
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL %s/retire: not retired within 64 cycles", name);
    end
    mem_inst = NOP_INST; mem_addr = 32'd0; exe_result = 32'd0;
    check({name, "/stall_cycles"}, stalls, exp_stalls);
    check({name, "/accessed"}, {31'd0, saw_req}, {31'd0, exp_access});
    check({name, "/req_dropped"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_inst = NOP_INST; mem_addr = 32'd0; exe_result = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check("reset/dmem_req", {31'd0, dmem_req}, 32'd0);
    check("reset/dmem_we", {31'd0, dmem_we}, 32'd0);
    check("reset/dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("reset/dmem_addr", dmem_addr, 32'd0);
    check("reset/dmem_wdata", dmem_wdata, 32'd0);
    check("reset/mem_result", mem_result, 32'd0);
    check("reset/wb_inst", wb_inst, NOP_INST);
    check("reset/bus_error", {31'd0, bus_error}, 32'd0);
    check("reset/misalign_fault", {31'd0, misalign_fault}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    //      name    inst    addr          data          rdata         dly acc daddr         wdata         wstrb  stl result        wb      berr mf
    run_op("add",   I_ADD,  32'h0,        32'h1234,     32'h0,        0,  0,  32'h0,        32'h0,        4'h0,  0,  32'h1234,     I_ADD,  0,   0);
    run_op("sb",    I_SB,   32'h1003,     32'hAB,       32'h0,        3,  1,  32'h1000,     32'hABABABAB, 4'h8,  4,  32'hAB,       I_SB,   0,   0);
    run_op("lb",    I_LB,   32'h2001,     32'h0,        32'h000080FF, 0,  1,  32'h2000,     32'h0,        4'h0,  1,  32'hFFFFFF80, I_LB,   0,   0);
    run_op("lbu",   I_LBU,  32'h2001,     32'h0,        32'h000080FF, 0,  1,  32'h2000,     32'h0,        4'h0,  1,  32'h00000080, I_LBU,  0,   0);
    run_op("lhu",   I_LHU,  32'h2002,     32'h0,        32'hBEEF0000, 0,  1,  32'h2000,     32'h0,        4'h0,  1,  32'h0000BEEF, I_LHU,  0,   0);
    run_op("lh",    I_LH,   32'h2002,     32'h0,        32'h80010000, 0,  1,  32'h2000,     32'h0,        4'h0,  1,  32'hFFFF8001, I_LH,   0,   0);
    run_op("sh",    I_SH,   32'h1002,     32'h12345678, 32'h0,        1,  1,  32'h1000,     32'h56785678, 4'hC,  2,  32'h12345678, I_SH,   0,   0);
    run_op("sw",    I_SW,   32'h1004,     32'hDEADBEEF, 32'h0,        2,  1,  32'h1004,     32'hDEADBEEF, 4'hF,  3,  32'hDEADBEEF, I_SW,   0,   0);
    run_op("lw_to", I_LW,   32'h4000,     32'h0,        32'h0,        -1, 1,  32'h4000,     32'h0,        4'h0,  4,  32'h0,        NOP_INST, 1, 0);
    run_op("add2",  I_ADD,  32'h0,        32'h55,       32'h0,        0,  0,  32'h0,        32'h0,        4'h0,  0,  32'h55,       I_ADD,  0,   0);
    run_op("ld_f3", I_LBAD, 32'h2000,     32'h77,       32'h0,        0,  0,  32'h0,        32'h0,        4'h0,  0,  32'h77,       I_LBAD, 0,   0);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op("lw_mis", I_LW,  32'h3002,     32'h0,        32'hCAFEF00D, 0,  0,  32'h0,        32'h0,        4'h0,  0,  32'h0,        NOP_INST, 0, 1);
`else
    run_op("lw_mis", I_LW,  32'h3002,     32'h0,        32'hCAFEF00D, 0,  1,  32'h3000,     32'h0,        4'h0,  1,  32'hCAFEF00D, I_LW,   0,   0);
`endif

    // Reset while an access is outstanding, then a stray ack.
    mem_inst = I_LW; mem_addr = 32'h5000; exe_result = 32'd0;
    @(posedge clk); #2;
    check("rst_mid/req_up", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; mem_inst = NOP_INST; mem_addr = 32'd0;
    @(posedge clk); #2;
    check("rst_mid/req", {31'd0, dmem_req}, 32'd0);
    check("rst_mid/wb_inst", wb_inst, NOP_INST);
    check("rst_mid/mem_result", mem_result, 32'd0);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("stray_ack/stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #2;
    dmem_ack = 1'b0;
    check("stray_ack/req", {31'd0, dmem_req}, 32'd0);
    check("stray_ack/wb_inst", wb_inst, NOP_INST);
    check("stray_ack/mem_result", mem_result, 32'd0);
    check("stray_ack/bus_error", {31'd0, bus_error}, 32'd0);

    run_op("add3",  I_ADD,  32'h0,        32'hCAFE,     32'h0,        0,  0,  32'h0,        32'h0,        4'h0,  0,  32'hCAFE,     I_ADD,  0,   0);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard/drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
